// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler:
// frame layout, scheduler states and the frame builder.
package uart_pkg;

    localparam int FRAME_W = 11;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    localparam logic [FRAME_W-1:0] IDLE_FRAME = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_GAP
    } sched_state_t;

    function automatic logic parity_bit(
        input logic [7:0] data,
        input logic       odd
    );
        return (^data) ^ odd;
    endfunction

    // Bit 0 leaves the shifter first: start, data LSB..MSB, bit 9, stop.
    function automatic logic [FRAME_W-1:0] build_frame(
        input logic [7:0] data,
        input logic       par_en,
        input logic       odd
    );
        logic bit9;
        bit9 = par_en ? parity_bit(data, odd) : STOP_BIT;
        return {STOP_BIT, bit9, data, START_BIT};
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin requester pick; the search starts one past
// the last granted index and the pointer moves on a grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic               baud_clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic               pick_valid,
    output logic [IDX_W-1:0]   pick_idx,
    output logic [NUM_REQ-1:0] pick_onehot,
    output logic [IDX_W-1:0]   last_idx
);

    logic [IDX_W-1:0] cand;

    // Walk from farthest to nearest so the nearest hit wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx = last_idx;
        cand = last_idx;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        if (pick_valid) begin
            pick_onehot[pick_idx] = 1'b1;
        end
    end

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            last_idx <= IDX_W'(NUM_REQ - 1);
        end else if (advance && pick_valid) begin
            last_idx <= pick_idx;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART Tx frame shifter among NUM_REQ byte producers:
// arbitrate, build the frame, track busy/done, then hold an idle gap.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PARITY_EN = 1,
    parameter int PARITY_ODD = 0,
    parameter int GAP_CYCLES = 16,
    parameter int BUSY_TIMEOUT = 8,
    localparam int IDX_W = $clog2(NUM_REQ)
) (
    input  logic                 baud_clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] req_data,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [FRAME_W-1:0]   frame_out,
    output logic                 frame_load,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic                 sched_active,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 timeout_err
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);
    localparam logic PAR_EN = (PARITY_EN != 0);
    localparam logic PAR_ODD = (PARITY_ODD != 0);

    sched_state_t       state;
    logic [7:0]         cnt;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               advance;
    logic [7:0]         pick_byte;

    // Requests only count while idle; elsewhere they are ignored.
    assign advance = (state == ST_IDLE);
    assign pick_byte = req_data[{pick_idx, 3'b000} +: 8];

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_arb (
        .baud_clk   (baud_clk),
        .reset_n    (reset_n),
        .req        (req),
        .advance    (advance),
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx),
        .pick_onehot(pick_onehot),
        .last_idx   (grant_idx)
    );

    always_ff @(posedge baud_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            gnt <= '0;
            frame_load <= 1'b0;
            frame_out <= IDLE_FRAME;
            sched_active <= 1'b0;
            timeout_err <= 1'b0;
            cnt <= '0;
        end else begin
            gnt <= '0;
            frame_load <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt <= pick_onehot;
                        frame_out <= build_frame(pick_byte, PAR_EN, PAR_ODD);
                        sched_active <= 1'b1;
                        cnt <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    frame_load <= 1'b1;
                    cnt <= '0;
                    state <= ST_WAIT_BUSY;
                end
                // A done here means the shifter was quick; skip WAIT_DONE.
                ST_WAIT_BUSY: begin
                    if (tx_done) begin
                        cnt <= '0;
                        state <= ST_GAP;
                    end else if (tx_busy) begin
                        cnt <= '0;
                        state <= ST_WAIT_DONE;
                    end else if (cnt == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        cnt <= '0;
                        state <= ST_GAP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (tx_done) begin
                        cnt <= '0;
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        sched_active <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    cnt <= '0;
                    sched_active <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: stimulus queues expected
// grants/frames, a monitor pops and compares them with timing.
module tb_uart_tx_scheduler;

    localparam int GAP = 16;
    localparam int TMO = 8;

    localparam logic [10:0] F0 = 11'b1_0_01011010_0;
    localparam logic [10:0] F1 = 11'b1_1_10000000_0;
    localparam logic [10:0] F2 = 11'b1_0_10100101_0;
    localparam logic [10:0] F3 = 11'b1_1_00000111_0;
    localparam logic [10:0] FO01 = 11'b1_0_00000001_0;
    localparam logic [10:0] FO00 = 11'b1_1_00000000_0;

    typedef struct {
        logic [3:0]  g;
        logic [10:0] f;
        logic [1:0]  idx;
    } exp_t;

    logic        baud_clk = 1'b0;
    logic        reset_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [10:0] frame_out;
    logic        frame_load;
    logic        tx_busy;
    logic        tx_done;
    logic        sched_active;
    logic [1:0]  grant_idx;
    logic        timeout_err;

    logic [3:0]  req_o;
    logic [31:0] req_data_o;
    logic [3:0]  gnt_o;
    logic [10:0] frame_out_o;
    logic        frame_load_o;
    logic        sched_active_o;
    logic [1:0]  grant_idx_o;
    logic        timeout_err_o;
    logic        tx_quiet = 1'b0;

    logic [10:0] fr [4] = '{F0, F1, F2, F3};

    exp_t q[$];
    exp_t q_odd[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int gcount = 0;
    int gcount_o = 0;
    int sh_mode = 1;
    int spur_req = 0;

    always #5 baud_clk = ~baud_clk;

    uart_tx_scheduler #(
        .NUM_REQ(4), .PARITY_EN(1), .PARITY_ODD(0),
        .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
    ) dut (
        .baud_clk    (baud_clk),
        .reset_n     (reset_n),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .frame_out   (frame_out),
        .frame_load  (frame_load),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .sched_active(sched_active),
        .grant_idx   (grant_idx),
        .timeout_err (timeout_err)
    );

    uart_tx_scheduler #(
        .NUM_REQ(4), .PARITY_EN(1), .PARITY_ODD(1),
        .GAP_CYCLES(GAP), .BUSY_TIMEOUT(TMO)
    ) dut_odd (
        .baud_clk    (baud_clk),
        .reset_n     (reset_n),
        .req         (req_o),
        .req_data    (req_data_o),
        .gnt         (gnt_o),
        .frame_out   (frame_out_o),
        .frame_load  (frame_load_o),
        .tx_busy     (tx_quiet),
        .tx_done     (tx_quiet),
        .sched_active(sched_active_o),
        .grant_idx   (grant_idx_o),
        .timeout_err (timeout_err_o)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grants(input int which, input int n, input int lim);
        int i;
        i = 0;
        while (((which == 0) ? gcount : gcount_o) < n && i < lim) begin
            @(negedge baud_clk);
            i++;
        end
        chk("grant_wait", 32'(((which == 0) ? gcount : gcount_o) >= n), 1);
    endtask

    task automatic wait_idle(input int which, input int lim);
        int i;
        i = 0;
        while (((which == 0) ? sched_active : sched_active_o) && i < lim) begin
            @(negedge baud_clk);
            i++;
        end
        chk("idle_wait", (which == 0) ? sched_active : sched_active_o, 0);
    endtask

    // Shifter model: busy two cycles after load, done ~160 cycles later.
    initial begin : shifter
        int sh_cnt;
        int spur_seen;
        sh_cnt = 0;
        spur_seen = 0;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge baud_clk);
            tx_done = 1'b0;
            if (sh_cnt == 0) tx_busy = 1'b0;
            if (!reset_n) begin
                sh_cnt = 0;
                tx_busy = 1'b0;
            end else if (frame_load) begin
                sh_cnt = (sh_mode == 1) ? 162 : (sh_mode == 2) ? 1 : 0;
            end else if (sh_cnt > 0) begin
                sh_cnt--;
                if (sh_cnt == 161) tx_busy = 1'b1;
                if (sh_cnt == 0) begin
                    tx_done = 1'b1;
                    tx_busy = (sh_mode == 2);
                end
            end
            if (spur_req != spur_seen) begin
                tx_done = 1'b1;
                spur_seen = spur_req;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic [10:0] last_f;
        bit load_due, load_due_o, done_pend, prev_act, prev_err;
        int load_cyc, done_cyc;
        last_f = '0;
        load_due = 0; load_due_o = 0; done_pend = 0;
        prev_act = 0; prev_err = 0;
        load_cyc = 0; done_cyc = 0;
        forever begin
            @(posedge baud_clk);
            #1;
            cyc++;
            if (!reset_n) begin
                load_due = 0; load_due_o = 0; done_pend = 0;
                prev_act = 0; prev_err = 0;
            end else begin
                if (load_due) begin
                    chk("load_after_gnt", frame_load, 1);
                    chk("load_frame", frame_out, last_f);
                    load_cyc = cyc;
                    load_due = 0;
                end else if (frame_load) begin
                    chk("stray_load", frame_load, 0);
                end
                if (gnt != 0) begin
                    if (q.size() == 0) begin
                        chk("unexpected_gnt", gnt, 0);
                    end else begin
                        e = q.pop_front();
                        chk("gnt", gnt, e.g);
                        chk("frame", frame_out, e.f);
                        chk("grant_idx", grant_idx, e.idx);
                    end
                    gcount++;
                    load_due = 1;
                    last_f = frame_out;
                end
                if (tx_done && sched_active) begin
                    done_cyc = cyc;
                    done_pend = 1;
                end
                if (timeout_err && !prev_err) begin
                    chk("timeout_delay", cyc - load_cyc, TMO);
                    done_cyc = cyc;
                    done_pend = 1;
                end
                if (prev_act && !sched_active) begin
                    if (done_pend) chk("gap_len", cyc - done_cyc, GAP);
                    done_pend = 0;
                end
                prev_act = sched_active;
                prev_err = timeout_err;
                if (load_due_o) begin
                    chk("odd_load", frame_load_o, 1);
                    load_due_o = 0;
                end
                if (gnt_o != 0) begin
                    if (q_odd.size() == 0) begin
                        chk("odd_unexpected_gnt", gnt_o, 0);
                    end else begin
                        e = q_odd.pop_front();
                        chk("odd_gnt", gnt_o, e.g);
                        chk("odd_frame", frame_out_o, e.f);
                        chk("odd_grant_idx", grant_idx_o, e.idx);
                    end
                    gcount_o++;
                    load_due_o = 1;
                end
            end
        end
    end

    initial begin : stim
        int i;
        reset_n = 1'b0;
        req = '0;
        req_data = {8'h07, 8'hA5, 8'h80, 8'h5A};
        req_o = '0;
        req_data_o = '0;
        #12;
        chk("rst_gnt", gnt, 0);
        chk("rst_load", frame_load, 0);
        chk("rst_frame", frame_out, 11'h7FF);
        chk("rst_active", sched_active, 0);
        chk("rst_idx", grant_idx, 3);
        chk("rst_err", timeout_err, 0);
        @(negedge baud_clk);
        reset_n = 1'b1;
        repeat (2) @(negedge baud_clk);

        // all requesters held: 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            q.push_back('{g: 4'(1 << (k % 4)), f: fr[k % 4], idx: 2'(k % 4)});
        end
        req = 4'hF;
        wait_grants(0, 8, 2500);
        req = '0;
        wait_idle(0, 300);

        // single request, even parity 0xA5
        q.push_back('{g: 4'b0100, f: F2, idx: 2'd2});
        req = 4'b0100;
        wait_grants(0, 9, 50);
        req = '0;
        wait_idle(0, 300);

        // shifter never busy: timeout, then next request after the gap
        sh_mode = 0;
        q.push_back('{g: 4'b0010, f: F1, idx: 2'd1});
        q.push_back('{g: 4'b1000, f: F3, idx: 2'd3});
        req = 4'b0010;
        wait_grants(0, 10, 50);
        req = 4'b1000;
        i = 0;
        while (!timeout_err && i < 50) begin
            @(negedge baud_clk);
            i++;
        end
        chk("timeout_seen", timeout_err, 1);
        sh_mode = 1;
        wait_grants(0, 11, 100);
        req = '0;
        wait_idle(0, 300);
        chk("err_sticky", timeout_err, 1);

        // spurious done while idle, then done together with busy
        spur_req++;
        repeat (3) @(negedge baud_clk);
        chk("spur_active", sched_active, 0);
        chk("spur_gnt", gnt, 0);
        sh_mode = 2;
        q.push_back('{g: 4'b0001, f: F0, idx: 2'd0});
        req = 4'b0001;
        wait_grants(0, 12, 50);
        req = '0;
        wait_idle(0, 100);
        sh_mode = 1;

        // reset in WAIT_DONE
        q.push_back('{g: 4'b0010, f: F1, idx: 2'd1});
        req = 4'b0010;
        wait_grants(0, 13, 50);
        req = '0;
        repeat (20) @(negedge baud_clk);
        chk("busy_active", sched_active, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_gnt", gnt, 0);
        chk("arst_load", frame_load, 0);
        chk("arst_frame", frame_out, 11'h7FF);
        chk("arst_active", sched_active, 0);
        chk("arst_idx", grant_idx, 3);
        chk("arst_err", timeout_err, 0);
        repeat (2) @(negedge baud_clk);
        reset_n = 1'b1;
        q.push_back('{g: 4'b0001, f: F0, idx: 2'd0});
        q.push_back('{g: 4'b1000, f: F3, idx: 2'd3});
        req = 4'b1001;
        wait_grants(0, 14, 50);
        req = 4'b1000;
        wait_grants(0, 15, 300);
        req = '0;
        wait_idle(0, 300);

        // odd parity instance
        q_odd.push_back('{g: 4'b0001, f: FO01, idx: 2'd0});
        req_data_o = 32'h0000_0001;
        req_o = 4'b0001;
        wait_grants(1, 1, 50);
        req_o = '0;
        wait_idle(1, 100);
        q_odd.push_back('{g: 4'b0001, f: FO00, idx: 2'd0});
        req_data_o = 32'h0000_0000;
        req_o = 4'b0001;
        wait_grants(1, 2, 50);
        req_o = '0;
        wait_idle(1, 100);
        chk("odd_timeout", timeout_err_o, 1);

        chk("queue_drained", q.size(), 0);
        chk("odd_queue_drained", q_odd.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errors);
        $finish;
    end

endmodule
